// File: rtl/sdram_burst_scheduler.sv
// rtl/sdram_burst_scheduler.sv - N-channel SDRAM burst scheduler
//
// Purpose: watches per-channel FIFO fill levels and selects one eligible
// channel. It issues one burst request (direction, address, length) to the
// SDRAM command core, waits for the acknowledge and the completion, and then
// advances that channel's wrapping address window. Single clock (CTRL_CLK).
//
// Optional feature macro: SCHED_RR_EN
//   defined   : round-robin arbitration; the search starts after the last
//               granted channel
//   undefined : fixed priority; the lowest eligible index wins
//
// Ports:
//   CTRL_CLK     in   controller clock
//   RESET_N      in   synchronous active-low reset
//   CH_MIN_ADDR  in   per-channel window start, channel i at [i*ASIZE +: ASIZE]
//   CH_MAX_ADDR  in   per-channel window end
//   CH_LENGTH    in   per-channel burst length; 0 disables the channel
//   CH_LOAD      in   per-channel address reload strobe
//   CH_LEVEL     in   per-channel FIFO fill level
//   REQ_WR       out  write burst request, held until REQ_ACK
//   REQ_RD       out  read burst request, held until REQ_ACK
//   REQ_ADDR     out  burst start address
//   REQ_LEN      out  burst length
//   REQ_ACK      in   core accepted the request (one-cycle pulse)
//   BURST_DONE   in   core finished the burst (one-cycle pulse)
//   GRANT        out  one-hot active channel
//   BUSY         out  high from grant until the address update completes
//   CH_ADDR      out  per-channel next-burst address
module sdram_burst_scheduler #(
  parameter int             NCH      = 4,
  parameter int             ASIZE    = 23,
  parameter int             LW       = 9,
  parameter int             LVW      = 16,
  parameter logic [NCH-1:0] CH_IS_WR = 4'b0001
) (
  input  logic                 CTRL_CLK,
  input  logic                 RESET_N,
  input  logic [NCH*ASIZE-1:0] CH_MIN_ADDR,
  input  logic [NCH*ASIZE-1:0] CH_MAX_ADDR,
  input  logic [NCH*LW-1:0]    CH_LENGTH,
  input  logic [NCH-1:0]       CH_LOAD,
  input  logic [NCH*LVW-1:0]   CH_LEVEL,
  output logic                 REQ_WR,
  output logic                 REQ_RD,
  output logic [ASIZE-1:0]     REQ_ADDR,
  output logic [LW-1:0]        REQ_LEN,
  input  logic                 REQ_ACK,
  input  logic                 BURST_DONE,
  output logic [NCH-1:0]       GRANT,
  output logic                 BUSY,
  output logic [NCH*ASIZE-1:0] CH_ADDR
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (LVW > LW) ? LVW : LW;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic             req_wr_q, req_wr_d;
  logic             req_rd_q, req_rd_d;
  logic [ASIZE-1:0] req_addr_q, req_addr_d;
  logic [LW-1:0]    req_len_q, req_len_d;
  logic [NCH-1:0]   grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             load_seen_q, load_seen_d;
  logic [ASIZE-1:0] ch_addr_q [NCH];
  logic [ASIZE-1:0] ch_addr_d [NCH];

  logic [ASIZE-1:0] min_a [NCH];
  logic [ASIZE-1:0] max_a [NCH];
  logic [LW-1:0]    len_a [NCH];
  logic [LVW-1:0]   lvl_a [NCH];
  logic [NCH-1:0]   elig;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign min_a[i] = CH_MIN_ADDR[i*ASIZE +: ASIZE];
    assign max_a[i] = CH_MAX_ADDR[i*ASIZE +: ASIZE];
    assign len_a[i] = CH_LENGTH[i*LW +: LW];
    assign lvl_a[i] = CH_LEVEL[i*LVW +: LVW];
    assign CH_ADDR[i*ASIZE +: ASIZE] = ch_addr_q[i];
    // A write channel needs a full burst buffered; a read channel needs room for one.
    assign elig[i] = (len_a[i] != '0) &&
                     (CH_IS_WR[i] ? (CW'(lvl_a[i]) >= CW'(len_a[i]))
                                  : (CW'(lvl_a[i]) <  CW'(len_a[i])));
  end

  // Arbitration
  logic          pick_found;
  logic [IW-1:0] pick_idx;

`ifdef SCHED_RR_EN
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] cand;

  // Walk the search order backwards so the last hit is the first channel after the pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = IW'((int'(rr_ptr_q) + k) % NCH);
      if (elig[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end
`else
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end
`endif

  // Window advance; the compare runs one bit wider so MAX-LENGTH cannot underflow.
  logic [ASIZE:0]   cur_x, max_x, len_x;
  logic             adv_wrap;
  logic [ASIZE-1:0] adv_addr;

  assign cur_x    = {1'b0, ch_addr_q[gidx_q]};
  assign max_x    = {1'b0, max_a[gidx_q]};
  assign len_x    = (ASIZE+1)'(req_len_q);
  assign adv_wrap = !((max_x > len_x) && (cur_x < (max_x - len_x)));
  assign adv_addr = adv_wrap ? min_a[gidx_q] : (ch_addr_q[gidx_q] + ASIZE'(req_len_q));

  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    req_wr_d    = req_wr_q;
    req_rd_d    = req_rd_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    load_seen_d = load_seen_q;
`ifdef SCHED_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    for (int i = 0; i < NCH; i++) ch_addr_d[i] = ch_addr_q[i];

    case (state_q)
      S_IDLE: begin
        if ((CH_LOAD == '0) && pick_found) begin
          state_d           = S_ISSUE;
          gidx_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          req_addr_d        = ch_addr_q[pick_idx];
          req_len_d         = len_a[pick_idx];
          req_wr_d          = CH_IS_WR[pick_idx];
          req_rd_d          = !CH_IS_WR[pick_idx];
          busy_d            = 1'b1;
          load_seen_d       = 1'b0;
`ifdef SCHED_RR_EN
          rr_ptr_d          = pick_idx;
`endif
        end
      end
      S_ISSUE: begin
        if (CH_LOAD[gidx_q]) load_seen_d = 1'b1;
        if (REQ_ACK) begin
          req_wr_d = 1'b0;
          req_rd_d = 1'b0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (CH_LOAD[gidx_q]) load_seen_d = 1'b1;
        if (BURST_DONE) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        // A reload during the burst pins the channel at MIN; drop the advance.
        if (!load_seen_q && !CH_LOAD[gidx_q]) ch_addr_d[gidx_q] = adv_addr;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < NCH; i++) begin
      if (CH_LOAD[i]) ch_addr_d[i] = min_a[i];
    end
  end

  always_ff @(posedge CTRL_CLK) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      gidx_q      <= '0;
      req_wr_q    <= 1'b0;
      req_rd_q    <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      load_seen_q <= 1'b0;
`ifdef SCHED_RR_EN
      rr_ptr_q    <= IW'(NCH - 1);
`endif
      for (int i = 0; i < NCH; i++) ch_addr_q[i] <= min_a[i];
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      req_wr_q    <= req_wr_d;
      req_rd_q    <= req_rd_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      load_seen_q <= load_seen_d;
`ifdef SCHED_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
      for (int i = 0; i < NCH; i++) ch_addr_q[i] <= ch_addr_d[i];
    end
  end

  assign REQ_WR   = req_wr_q;
  assign REQ_RD   = req_rd_q;
  assign REQ_ADDR = req_addr_q;
  assign REQ_LEN  = req_len_q;
  assign GRANT    = grant_q;
  assign BUSY     = busy_q;

endmodule
